// File: rtl/snn_pkg.sv
// Shared definitions for the SNN output collector: packet field positions,
// the default-width packet layout and the per-bank state encoding.
package snn_pkg;

    localparam int unsigned DIR_LSB   = 0;
    localparam int unsigned DIR_W     = 2;
    localparam int unsigned XHOP_LSB  = 2;
    localparam int unsigned XHOP_W    = 2;
    localparam int unsigned YHOP_BIT  = 4;
    localparam int unsigned TS_BIT    = 5;
    localparam int unsigned SPIKE_BIT = 9;
    localparam int unsigned PE_LSB    = 10;
    localparam int unsigned PE_W      = 2;

    // Residue occupies the top OUTPUT_WIDTH bits of a 3*FILTER_WIDTH+9 packet.
    function automatic int unsigned residue_msb(input int unsigned filter_width);
        return 3 * filter_width + 8;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } bank_state_e;

    // Packet layout at the default widths (FILTER_WIDTH=8, OUTPUT_WIDTH=12).
    typedef struct packed {
        logic [11:0] residue;
        logic [8:0]  rsvd;
        logic [1:0]  pe;
        logic        spike;
        logic [2:0]  zero;
        logic        ts;
        logic        yhop;
        logic [1:0]  xhop;
        logic [1:0]  dir;
    } pkt_t;

endpackage

// File: rtl/snn_frame_bank.sv
// One timestep's frame under reassembly: per-PE seen/spike/residue storage
// plus the FILL/FULL state that gates acceptance and hand-off.
module snn_frame_bank
    import snn_pkg::*;
#(
    parameter int unsigned NUM_PE       = 3,
    parameter int unsigned OUTPUT_WIDTH = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr,
    input  logic [PE_W-1:0]                wr_pe,
    input  logic                           wr_spike,
    input  logic [OUTPUT_WIDTH-1:0]        wr_residue,
    input  logic                           clr,
    output logic                           full,
    output logic [NUM_PE-1:0]              seen,
    output logic [NUM_PE-1:0]              spikes,
    output logic [NUM_PE*OUTPUT_WIDTH-1:0] residue
);

    bank_state_e       state_q;
    bank_state_e       state_d;
    logic [NUM_PE-1:0] pe_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pe_onehot = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            if (wr_pe == PE_W'(i)) begin
                pe_onehot[i] = 1'b1;
            end
        end
        case (state_q)
            FILL: if (wr && (&(seen | pe_onehot))) state_d = FULL;
            FULL: if (clr) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    assign full = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen    <= '0;
            spikes  <= '0;
            residue <= '0;
        end else if (clr) begin
            seen    <= '0;
            spikes  <= '0;
            residue <= '0;
        end else if (wr) begin
            for (int i = 0; i < int'(NUM_PE); i++) begin
                if (pe_onehot[i]) begin
                    seen[i]                               <= 1'b1;
                    spikes[i]                             <= wr_spike;
                    residue[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= wr_residue;
                end
            end
        end
    end

endmodule

// File: rtl/snn_output_collector.sv
// Mesh egress receiver: decodes result packets into two timestep banks and
// hands completed frames downstream strictly in timestep order.
module snn_output_collector
    import snn_pkg::*;
#(
    parameter int unsigned FILTER_WIDTH = 8,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned NUM_PE       = 3,
    parameter int unsigned PKT_WIDTH    = 3 * FILTER_WIDTH + 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pkt_valid,
    output logic                           pkt_ready,
    input  logic [PKT_WIDTH-1:0]           pkt_data,
    output logic                           frm_valid,
    input  logic                           frm_ready,
    output logic                           frm_timestep,
    output logic [NUM_PE-1:0]              frm_spikes,
    output logic [NUM_PE*OUTPUT_WIDTH-1:0] frm_residue,
    output logic                           err_dup,
    output logic                           err_pe,
    output logic [15:0]                    frames_done
);

    localparam int unsigned RES_MSB = residue_msb(FILTER_WIDTH);

    logic                           pkt_ts;
    logic [PE_W-1:0]                pkt_pe;
    logic                           pkt_spike;
    logic [OUTPUT_WIDTH-1:0]        pkt_residue;
    logic                           accept_c;
    logic                           pe_bad_c;
    logic                           dup_c;
    logic                           handoff_c;
    logic                           expect_ts;
    logic                           unused_c;

    logic [1:0]                     bank_full;
    logic [1:0]                     bank_wr;
    logic [1:0]                     bank_clr;
    logic [NUM_PE-1:0]              bank_seen    [2];
    logic [NUM_PE-1:0]              bank_spikes  [2];
    logic [NUM_PE*OUTPUT_WIDTH-1:0] bank_residue [2];

    assign pkt_ts      = pkt_data[TS_BIT];
    assign pkt_pe      = pkt_data[PE_LSB +: PE_W];
    assign pkt_spike   = pkt_data[SPIKE_BIT];
    assign pkt_residue = pkt_data[RES_MSB -: OUTPUT_WIDTH];
    // Direction, hop and zero fields carry no meaning at the egress.
    assign unused_c    = ^pkt_data;

    // Ready follows the addressed bank, so a held frame never blocks the other timestep.
    assign pkt_ready = !bank_full[pkt_ts];
    assign accept_c  = pkt_valid && pkt_ready;
    assign pe_bad_c  = 32'(pkt_pe) >= NUM_PE;
    assign handoff_c = frm_valid && frm_ready;

    always_comb begin
        dup_c    = 1'b0;
        bank_wr  = '0;
        bank_clr = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            if (pkt_pe == PE_W'(i) && bank_seen[pkt_ts][i]) begin
                dup_c = 1'b1;
            end
        end
        if (accept_c && !pe_bad_c && !dup_c) begin
            bank_wr[pkt_ts] = 1'b1;
        end
        if (handoff_c) begin
            bank_clr[expect_ts] = 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        snn_frame_bank #(
            .NUM_PE       (NUM_PE),
            .OUTPUT_WIDTH (OUTPUT_WIDTH)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr         (bank_wr[b]),
            .wr_pe      (pkt_pe),
            .wr_spike   (pkt_spike),
            .wr_residue (pkt_residue),
            .clr        (bank_clr[b]),
            .full       (bank_full[b]),
            .seen       (bank_seen[b]),
            .spikes     (bank_spikes[b]),
            .residue    (bank_residue[b])
        );
    end

    // Frame port is a register-driven mux of the bank whose turn it is.
    assign frm_valid    = bank_full[expect_ts];
    assign frm_timestep = expect_ts;
    assign frm_spikes   = bank_spikes[expect_ts];
    assign frm_residue  = bank_residue[expect_ts];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_ts   <= 1'b0;
            err_dup     <= 1'b0;
            err_pe      <= 1'b0;
            frames_done <= '0;
        end else begin
            err_dup <= accept_c && !pe_bad_c && dup_c;
            err_pe  <= accept_c && pe_bad_c;
            if (handoff_c) begin
                expect_ts   <= !expect_ts;
                frames_done <= frames_done + 16'd1;
            end
        end
    end

endmodule
